// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the fifo_rd_stream read adapter: prefetch depth and
// buffer occupancy encoding.
package fifo_rd_stream_pkg;

  localparam int PREFETCH_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Words already owned by the adapter (buffered + in flight) after this cycle's pop.
  function automatic logic [2:0] pending(occ_e occ, logic inflight, logic pop);
    return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bundles the sync_fifo read port and the downstream valid/ready stream
// seen by fifo_rd_stream.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  fifo_empty_i;
  logic                  fifo_re_o;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;

  modport master (
    input  fifo_empty_i,
    input  fifo_data_i,
    input  m_ready_i,
    output fifo_re_o,
    output m_valid_o,
    output m_data_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_data_i,
    output m_ready_i,
    input  fifo_re_o,
    input  m_valid_o,
    input  m_data_o
  );

endinterface

// File: rtl/fifo_rd_stream_buf2.sv
// Two-entry register buffer with head/tail pointers; occupancy is the FSM state.
//   state | meaning
//   EMPTY | no buffered words, stream invalid
//   ONE   | one word buffered at head
//   TWO   | both entries full, no landing allowed
module fifo_rd_stream_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  pop_i,
  output occ_e                  occ_o,
  output logic [DATA_WIDTH-1:0] head_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [PREFETCH_DEPTH];
  logic                  head_q;
  logic                  tail_q;
  occ_e                  occ_q;
  occ_e                  occ_d;
  logic                  pop_ok;

  assign pop_ok      = pop_i & (occ_q != EMPTY);
  assign occ_o       = occ_q;
  assign head_data_o = mem_q[head_q];

  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      EMPTY: begin
        if (wr_i) occ_d = ONE;
      end
      ONE: begin
        if (wr_i && !pop_ok)      occ_d = TWO;
        else if (!wr_i && pop_ok) occ_d = EMPTY;
      end
      TWO: begin
        if (pop_ok && !wr_i) occ_d = ONE;
      end
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= EMPTY;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      for (int i = 0; i < PREFETCH_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      occ_q  <= EMPTY;
      head_q <= 1'b0;
      tail_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (wr_i) begin
        mem_q[tail_q] <= wr_data_i;
        tail_q        <= ~tail_q;
      end
      if (pop_ok) head_q <= ~head_q;
    end
  end

`ifndef SYNTHESIS
  // The re throttle guarantees a landing never meets a full buffer.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n)
    !(wr_i && !flush_i && occ_q == TWO));
`endif

endmodule

// File: rtl/fifo_rd_stream.sv
// sync_fifo read side to valid/ready stream adapter with 2-deep prefetch.
// Optional beat/stall counters are built when FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  parameter int CNT_WIDTH  = 32
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 flush_i,
`ifdef FIFO_RD_STREAM_STATS_EN
  output logic [CNT_WIDTH-1:0] beat_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
`endif
  fifo_rd_stream_if.master     bus
);

  occ_e                  occ;
  logic                  inflight_q;
  logic                  pop;
  logic [2:0]            pend;
  logic [DATA_WIDTH-1:0] head_data;

  assign bus.m_valid_o = (occ != EMPTY);
  assign bus.m_data_o  = head_data;
  assign pop           = bus.m_valid_o & bus.m_ready_i & ~flush_i;
  assign pend          = pending(occ, inflight_q, pop);

  // Ready feeds re combinationally so a draining consumer keeps the FIFO streaming.
  assign bus.fifo_re_o = rst_n & ~flush_i & ~bus.fifo_empty_i
                         & (pend < 3'(PREFETCH_DEPTH));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= bus.fifo_re_o;
  end

  fifo_rd_stream_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .wr_i        (inflight_q & ~flush_i),
    .wr_data_i   (bus.fifo_data_i),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_data_o (head_data)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else if (flush_i) begin
      beat_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (pop)                             beat_cnt_o  <= beat_cnt_o + 1'b1;
      if (bus.m_valid_o && !bus.m_ready_i) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a behavioural sync_fifo feeds the DUT,
// expected beats are queued at push time and a monitor checks every accepted beat.
module tb_fifo_rd_stream;

  localparam int DW = 32;

  logic clk_i   = 1'b0;
  logic rst_n   = 1'b0;
  logic flush_i = 1'b0;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] beat_cnt;
  logic [31:0] stall_cnt;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
`ifdef FIFO_RD_STREAM_STATS_EN
    .beat_cnt_o  (beat_cnt),
    .stall_cnt_o (stall_cnt),
`endif
    .bus         (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] fmem [64];
  int            wr_idx = 0;
  int            rd_idx = 0;

  assign bus.fifo_empty_i = (wr_idx == rd_idx);

  always @(posedge clk_i) begin
    if (bus.fifo_re_o) begin
      bus.fifo_data_i <= fmem[rd_idx % 64];
      rd_idx          <= rd_idx + 1;
    end
  end

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;
  int            n_beats = 0;
  int            outst   = 0;
  int            max_out = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic push(input logic [DW-1:0] w, input bit expect_beat);
    fmem[wr_idx % 64] = w;
    wr_idx++;
    if (expect_beat) exp_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.m_valid_o) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n < 200) passes++;
    else $display("FAIL %s: timeout with %0d beats pending, required 0", name, exp_q.size());
    repeat (2) tick();
  endtask

  // Monitor: scoreboard compare plus buffered+in-flight word count.
  always @(negedge clk_i) begin
    if (!rst_n || flush_i) begin
      outst = 0;
    end else begin
      if (bus.m_valid_o && bus.m_ready_i) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got 0x%0h required no beat", bus.m_data_o);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("beat_data", bus.m_data_o, mon_exp);
        end
      end
      outst = outst + int'(bus.fifo_re_o) - int'(bus.m_valid_o && bus.m_ready_i);
      if (outst > max_out) max_out = outst;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  initial begin
    int nre;
    int nb0;
    bus.m_ready_i = 1'b1;

    // 1: reset with a non-empty FIFO
    push(32'h55, 1'b1);
    repeat (2) begin
      @(negedge clk_i);
      chk("rst_re", bus.fifo_re_o, 0);
      chk("rst_valid", bus.m_valid_o, 0);
      chk("rst_data", bus.m_data_o, 0);
    end
    tick();
    rst_n = 1'b1;
    wait_idle("t1_drain");

    // 2: three words, free-flowing consumer, latency and no bubbles
    push(32'hA, 1'b1); push(32'hB, 1'b1); push(32'hC, 1'b1);
    @(negedge clk_i); chk("t2_re_n0", bus.fifo_re_o, 1); chk("t2_valid_n0", bus.m_valid_o, 0);
    @(negedge clk_i); chk("t2_re_n1", bus.fifo_re_o, 1); chk("t2_valid_n1", bus.m_valid_o, 0);
    @(negedge clk_i); chk("t2_re_n2", bus.fifo_re_o, 1); chk("t2_data_n2", bus.m_data_o, 32'hA);
    @(negedge clk_i); chk("t2_re_n3", bus.fifo_re_o, 0); chk("t2_data_n3", bus.m_data_o, 32'hB);
    @(negedge clk_i); chk("t2_valid_n4", bus.m_valid_o, 1); chk("t2_data_n4", bus.m_data_o, 32'hC);
    @(negedge clk_i); chk("t2_valid_n5", bus.m_valid_o, 0);
    wait_idle("t2_drain");

    // 3: backpressure holds head, re stops at two words
    bus.m_ready_i = 1'b0;
    push(32'hA, 1'b1); push(32'hB, 1'b1); push(32'hC, 1'b1); push(32'hD, 1'b1);
    nre = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      if (bus.fifo_re_o) nre++;
      if (i >= 2) begin
        chk("t3_hold_valid", bus.m_valid_o, 1);
        chk("t3_hold_data", bus.m_data_o, 32'hA);
      end
    end
    chk("t3_re_count", nre, 2);
    tick();
    bus.m_ready_i = 1'b1;
    wait_idle("t3_drain");

    // 4: toggling ready, eight words
    max_out = 0;
    nb0 = n_beats;
    for (int w = 1; w <= 8; w++) push(w, 1'b1);
    for (int i = 0; i < 24; i++) begin
      tick();
      bus.m_ready_i = (i % 2 == 0);
    end
    tick();
    bus.m_ready_i = 1'b1;
    wait_idle("t4_drain");
    chk("t4_beat_count", n_beats - nb0, 8);
    chk("t4_occ_bound", max_out <= 2, 1);

    // 5: flush with one word buffered and one landing
    bus.m_ready_i = 1'b0;
    push(32'h11, 1'b0); push(32'h22, 1'b0); push(32'h33, 1'b1); push(32'h44, 1'b1);
    tick();
    tick();
    flush_i = 1'b1;
    @(negedge clk_i); chk("t5_flush_re", bus.fifo_re_o, 0);
    tick();
    flush_i = 1'b0;
    @(negedge clk_i); chk("t5_post_valid", bus.m_valid_o, 0);
    tick();
    bus.m_ready_i = 1'b1;
    wait_idle("t5_drain");

`ifdef FIFO_RD_STREAM_STATS_EN
    // 6: four beats, three stall cycles, then flush clears counters
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    bus.m_ready_i = 1'b0;
    push(32'h61, 1'b1); push(32'h62, 1'b1); push(32'h63, 1'b1); push(32'h64, 1'b1);
    repeat (5) tick();
    bus.m_ready_i = 1'b1;
    wait_idle("t6_drain");
    @(negedge clk_i);
    chk("t6_beat_cnt", beat_cnt, 4);
    chk("t6_stall_cnt", stall_cnt, 3);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("t6_beat_clr", beat_cnt, 0);
    chk("t6_stall_clr", stall_cnt, 0);
`endif

    chk("final_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
